dsram_arbiter: RTL and testbench

Shares the single-port, pipelined data SRAM between two sram-like requesters: the CPU memory path (port C, driven by the execute/memory stages) and an auxiliary master (port D, debug/DMA). Each cycle it grants at most one request, drives the SRAM, and tracks every accepted access through a fixed-latency response pipeline. It returns `data_ok` and read data to the owning port. It sits between the pipeline stages and the `data_sram_*` pins at the CPU top level.

---
 rtl/dsram_arbiter_pkg.sv | 25 ++
 rtl/dsram_rsp_pipe.sv | 39 +++
 rtl/dsram_arbiter.sv | 132 +++++++++++++
 tb/tb_dsram_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsram_arbiter_pkg.sv
// Shared definitions for the data-SRAM arbiter: owner encoding, request bus
// layout and the response-pipeline stage record.
package dsram_arbiter_pkg;

   typedef enum logic {
      DSRAM_OWN_C = 1'b0,
      DSRAM_OWN_D = 1'b1
   } owner_e;

   // wr + wstrb + addr + wdata
   localparam int DSRAM_REQ_WD = 69;

   typedef struct packed {
      logic        wr;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } dsram_req_t;

   typedef struct packed {
      logic   valid;
      owner_e owner;
   } rsp_stage_t;

endpackage

// File: rtl/dsram_rsp_pipe.sv
// Fixed-latency response tracker: LAT stages of {valid, owner}, shifted every
// cycle and cleared asynchronously, so in-flight accesses vanish on reset.
module dsram_rsp_pipe
   import dsram_arbiter_pkg::*;
#(
   parameter int LAT = 1
) (
   input  logic   clk,
   input  logic   resetn,
   input  logic   valid_i,
   input  owner_e owner_i,
   output logic   valid_o,
   output owner_e owner_o
);

   rsp_stage_t [LAT-1:0] pipe_q;
   rsp_stage_t [LAT-1:0] pipe_d;

   always_comb begin
      pipe_d[0] = '{valid: valid_i, owner: owner_i};
      for (int i = 1; i < LAT; i++) begin
         pipe_d[i] = pipe_q[i-1];
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // stage samples its neighbour's old value and the chain shifts by one.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pipe_q <= '0;
      end else begin
         pipe_q <= pipe_d;
      end
   end

   assign valid_o = pipe_q[LAT-1].valid;
   assign owner_o = pipe_q[LAT-1].owner;

endmodule

// File: rtl/dsram_arbiter.sv
// Two-port arbiter for the single-port pipelined data SRAM.
// Define DSRAM_ARB_RR_EN for round-robin arbitration; otherwise port C has fixed priority.
module dsram_arbiter
   import dsram_arbiter_pkg::*;
#(
   parameter int LAT   = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             resetn,

   input  logic             c_req,
   input  logic             c_wr,
   input  logic [3:0]       c_wstrb,
   input  logic [31:0]      c_addr,
   input  logic [31:0]      c_wdata,
   output logic             c_addr_ok,
   output logic             c_data_ok,
   output logic [31:0]      c_rdata,

   input  logic             d_req,
   input  logic             d_wr,
   input  logic [3:0]       d_wstrb,
   input  logic [31:0]      d_addr,
   input  logic [31:0]      d_wdata,
   output logic             d_addr_ok,
   output logic             d_data_ok,
   output logic [31:0]      d_rdata,

   output logic             data_sram_en,
   output logic [3:0]       data_sram_wen,
   output logic [31:0]      data_sram_addr,
   output logic [31:0]      data_sram_wdata,
   input  logic [31:0]      data_sram_rdata,

   output logic [CNT_W-1:0] conflict_cnt
);

   logic                    any_req;
   logic                    conflict;
   owner_e                  winner;
   logic                    gnt;
   logic                    sel_d;
   logic [DSRAM_REQ_WD-1:0] c_raw;
   logic [DSRAM_REQ_WD-1:0] d_raw;
   dsram_req_t              win_req;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic                    rsp_valid;
   owner_e                  rsp_owner;

   assign any_req  = c_req | d_req;
   assign conflict = c_req & d_req;

`ifdef DSRAM_ARB_RR_EN
   owner_e last_q;
   owner_e last_d;
`endif

   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin
      winner = DSRAM_OWN_C;
      if (!c_req && d_req) begin
         winner = DSRAM_OWN_D;
      end
`ifdef DSRAM_ARB_RR_EN
      if (conflict && last_q == DSRAM_OWN_C) begin
         winner = DSRAM_OWN_D;
      end
      last_d = any_req ? winner : last_q;
`endif
   end

`ifdef DSRAM_ARB_RR_EN
   // Reset to D so that C takes the first conflict after reset.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         last_q <= DSRAM_OWN_D;
      end else begin
         last_q <= last_d;
      end
   end
`endif

   // Externally visible grant is held off while reset is asserted.
   assign gnt   = resetn & any_req;
   assign sel_d = gnt & (winner == DSRAM_OWN_D);

   assign c_raw   = {c_wr, c_wstrb, c_addr, c_wdata};
   assign d_raw   = {d_wr, d_wstrb, d_addr, d_wdata};
   assign win_req = sel_d ? d_raw : c_raw;

   assign c_addr_ok       = gnt & (winner == DSRAM_OWN_C);
   assign d_addr_ok       = sel_d;
   assign data_sram_en    = gnt;
   assign data_sram_wen   = (gnt && win_req.wr) ? win_req.wstrb : 4'b0000;
   assign data_sram_addr  = win_req.addr;
   assign data_sram_wdata = win_req.wdata;

   always_comb begin
      cnt_d = cnt_q;
      if (conflict && cnt_q != {CNT_W{1'b1}}) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign conflict_cnt = cnt_q;

   dsram_rsp_pipe #(.LAT(LAT)) u_rsp_pipe (
      .clk     (clk),
      .resetn  (resetn),
      .valid_i (any_req),
      .owner_i (winner),
      .valid_o (rsp_valid),
      .owner_o (rsp_owner)
   );

   assign c_data_ok = resetn & rsp_valid & (rsp_owner == DSRAM_OWN_C);
   assign d_data_ok = resetn & rsp_valid & (rsp_owner == DSRAM_OWN_D);
   assign c_rdata   = data_sram_rdata;
   assign d_rdata   = data_sram_rdata;

endmodule

// File: tb/tb_dsram_arbiter.sv
// Bench for dsram_arbiter: two instances (LAT=1/CNT_W=16 and LAT=3/CNT_W=2)
// share stimulus and are each checked against a schedule-based model.
module tb_dsram_arbiter;

   logic clk = 1'b0;
   logic resetn;
   always #5 clk = ~clk;

   logic        c_req, c_wr, d_req, d_wr;
   logic [3:0]  c_wstrb, d_wstrb;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;

   logic        c_addr_ok [2];
   logic        c_data_ok [2];
   logic        d_addr_ok [2];
   logic        d_data_ok [2];
   logic [31:0] c_rdata [2];
   logic [31:0] d_rdata [2];
   logic        sram_en [2];
   logic [3:0]  sram_wen [2];
   logic [31:0] sram_addr [2];
   logic [31:0] sram_wdata [2];
   logic [31:0] sram_rdata [2];
   logic [15:0] cnt0;
   logic [1:0]  cnt1;

   dsram_arbiter #(.LAT(1), .CNT_W(16)) u_dut_l1 (
      .clk(clk), .resetn(resetn),
      .c_req(c_req), .c_wr(c_wr), .c_wstrb(c_wstrb), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_addr_ok(c_addr_ok[0]), .c_data_ok(c_data_ok[0]), .c_rdata(c_rdata[0]),
      .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_addr_ok(d_addr_ok[0]), .d_data_ok(d_data_ok[0]), .d_rdata(d_rdata[0]),
      .data_sram_en(sram_en[0]), .data_sram_wen(sram_wen[0]), .data_sram_addr(sram_addr[0]),
      .data_sram_wdata(sram_wdata[0]), .data_sram_rdata(sram_rdata[0]),
      .conflict_cnt(cnt0)
   );

   dsram_arbiter #(.LAT(3), .CNT_W(2)) u_dut_l3 (
      .clk(clk), .resetn(resetn),
      .c_req(c_req), .c_wr(c_wr), .c_wstrb(c_wstrb), .c_addr(c_addr), .c_wdata(c_wdata),
      .c_addr_ok(c_addr_ok[1]), .c_data_ok(c_data_ok[1]), .c_rdata(c_rdata[1]),
      .d_req(d_req), .d_wr(d_wr), .d_wstrb(d_wstrb), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_addr_ok(d_addr_ok[1]), .d_data_ok(d_data_ok[1]), .d_rdata(d_rdata[1]),
      .data_sram_en(sram_en[1]), .data_sram_wen(sram_wen[1]), .data_sram_addr(sram_addr[1]),
      .data_sram_wdata(sram_wdata[1]), .data_sram_rdata(sram_rdata[1]),
      .conflict_cnt(cnt1)
   );

   function automatic logic [31:0] init_word(input int i);
      return (i == 'h40) ? 32'hDEADBEEF : (32'hA5A50000 | 32'(i));
   endfunction

   // SRAM models: byte-writable, read data delivered LAT cycles after enable.
   logic [31:0] mem [2][256];
   logic [31:0] rd_line [2][4];
   logic        mem_ready = 1'b0;

   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int k = 0; k < 2; k++)
            for (int i = 0; i < 256; i++) mem[k][i] <= init_word(i);
         mem_ready <= 1'b1;
      end else begin
         for (int k = 0; k < 2; k++) begin
            if (sram_en[k])
               for (int b = 0; b < 4; b++)
                  if (sram_wen[k][b]) mem[k][sram_addr[k][9:2]][8*b +: 8] <= sram_wdata[k][8*b +: 8];
            rd_line[k][0] <= mem[k][sram_addr[k][9:2]];
            for (int j = 1; j < 4; j++) rd_line[k][j] <= rd_line[k][j-1];
         end
      end
   end

   assign sram_rdata[0] = rd_line[0][0];
   assign sram_rdata[1] = rd_line[1][2];

   // Reference model: each accepted access is booked into the cycle it must answer in.
   typedef struct {
      bit          v;
      bit          own_d;
      bit          wr;
      logic [31:0] data;
   } rsp_t;

   localparam int LATS [2] = '{1, 3};
   localparam int CMAX [2] = '{65535, 3};

   rsp_t        sched [2][8];
   int          mcnt [2];
   logic [31:0] refmem [2][256];
   bit          mlast_d;
   int          cyc = 0;
   bit          last_gc, last_gd;
   int          checks = 0;
   int          errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 8; i++) sched[k][i].v = 1'b0;
         mcnt[k] = 0;
      end
      mlast_d = 1'b1;
   endtask

   function automatic bit pick_d();
      if (c_req && d_req) begin
`ifdef DSRAM_ARB_RR_EN
         return !mlast_d;
`else
         return 1'b0;
`endif
      end
      return d_req;
   endfunction

   task automatic cycle();
      bit          any, wd, ewr;
      logic [3:0]  estrb;
      logic [31:0] ea, ewdat, obs_cnt;
      rsp_t        s;
      @(negedge clk);
      if (!resetn) model_reset();
      any   = resetn && (c_req || d_req);
      wd    = any && pick_d();
      ea    = wd ? d_addr  : c_addr;
      ewdat = wd ? d_wdata : c_wdata;
      ewr   = wd ? d_wr    : c_wr;
      estrb = wd ? d_wstrb : c_wstrb;
      for (int k = 0; k < 2; k++) begin
         s = sched[k][cyc % 8];
         check($sformatf("c_addr_ok[%0d] cyc%0d", k, cyc), 32'(c_addr_ok[k]), 32'(any && !wd));
         check($sformatf("d_addr_ok[%0d] cyc%0d", k, cyc), 32'(d_addr_ok[k]), 32'(wd));
         check($sformatf("sram_en[%0d] cyc%0d", k, cyc), 32'(sram_en[k]), 32'(any));
         check($sformatf("sram_wen[%0d] cyc%0d", k, cyc), 32'(sram_wen[k]),
               32'((any && ewr) ? estrb : 4'b0000));
         check($sformatf("sram_addr[%0d] cyc%0d", k, cyc), sram_addr[k], ea);
         check($sformatf("sram_wdata[%0d] cyc%0d", k, cyc), sram_wdata[k], ewdat);
         check($sformatf("c_data_ok[%0d] cyc%0d", k, cyc), 32'(c_data_ok[k]), 32'(s.v && !s.own_d));
         check($sformatf("d_data_ok[%0d] cyc%0d", k, cyc), 32'(d_data_ok[k]), 32'(s.v && s.own_d));
         if (s.v && !s.wr)
            check($sformatf("rdata[%0d] cyc%0d", k, cyc), s.own_d ? d_rdata[k] : c_rdata[k], s.data);
         obs_cnt = (k == 0) ? 32'(cnt0) : 32'(cnt1);
         check($sformatf("conflict_cnt[%0d] cyc%0d", k, cyc), obs_cnt, 32'(mcnt[k]));
      end
      @(posedge clk);
      last_gc = any && !wd;
      last_gd = wd;
      if (resetn) begin
         for (int k = 0; k < 2; k++) begin
            sched[k][cyc % 8].v = 1'b0;
            if (any) begin
               sched[k][(cyc + LATS[k]) % 8] = '{1'b1, wd, ewr, refmem[k][ea[9:2]]};
               if (ewr)
                  for (int b = 0; b < 4; b++)
                     if (estrb[b]) refmem[k][ea[9:2]][8*b +: 8] = ewdat[8*b +: 8];
            end
            if (c_req && d_req && mcnt[k] < CMAX[k]) mcnt[k]++;
         end
         if (any) mlast_d = wd;
      end
      cyc++;
      #1;
   endtask

   task automatic set_c(input bit req, input bit wr, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] data);
      c_req = req; c_wr = wr; c_wstrb = strb; c_addr = addr; c_wdata = data;
   endtask

   task automatic set_d(input bit req, input bit wr, input logic [3:0] strb,
                        input logic [31:0] addr, input logic [31:0] data);
      d_req = req; d_wr = wr; d_wstrb = strb; d_addr = addr; d_wdata = data;
   endtask

   task automatic idle(input int n);
      set_c(0, 0, 4'h0, 32'h0, 32'h0);
      set_d(0, 0, 4'h0, 32'h0, 32'h0);
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      for (int k = 0; k < 2; k++)
         for (int i = 0; i < 256; i++) refmem[k][i] = init_word(i);
      model_reset();

      // Reset with live requests: everything must stay quiet.
      resetn = 1'b0;
      set_c(1, 1, 4'hF, 32'h40, 32'h1111_1111);
      set_d(1, 0, 4'h0, 32'h80, 32'h0);
      cycle();
      cycle();
      #0 resetn = 1'b1;

      // C read of 0x100, then D partial write and read-back of 0x200.
      set_c(1, 0, 4'hF, 32'h100, 32'h0);
      set_d(0, 0, 4'h0, 32'h0, 32'h0);
      cycle();
      idle(4);
      set_d(1, 1, 4'h3, 32'h200, 32'h12345678);
      cycle();
      idle(4);
      set_d(1, 0, 4'h0, 32'h200, 32'h0);
      cycle();
      idle(4);

      // Four cycles of continuous contention.
      set_c(1, 0, 4'h0, 32'h104, 32'h0);
      set_d(1, 0, 4'h0, 32'h204, 32'h0);
      for (int i = 0; i < 4; i++) cycle();
      check("conflict_cnt_l1_after_4", 32'(cnt0), 32'd4);
      check("conflict_cnt_l3_saturated", 32'(cnt1), 32'd3);
      idle(4);

      // Alternating single-port grants, back to back.
      for (int i = 0; i < 8; i++) begin
         if (i % 2 == 0) begin
            set_c(1, i[1], 4'hC, 32'(i * 4), 32'hC0DE_0000 | 32'(i));
            set_d(0, 0, 4'h0, 32'h0, 32'h0);
         end else begin
            set_c(0, 0, 4'h0, 32'h0, 32'h0);
            set_d(1, i[1], 4'h5, 32'(i * 4), 32'hD0DE_0000 | 32'(i));
         end
         cycle();
      end
      idle(4);

      // Reset pulse with two accesses in flight.
      set_c(1, 0, 4'h0, 32'h100, 32'h0);
      cycle();
      set_c(0, 0, 4'h0, 32'h0, 32'h0);
      set_d(1, 0, 4'h0, 32'h200, 32'h0);
      cycle();
      resetn = 1'b0;
      idle(1);
      resetn = 1'b1;
      idle(5);
      check("conflict_cnt_l1_post_reset", 32'(cnt0), 32'd0);
      set_c(1, 0, 4'h0, 32'h10, 32'h0);
      set_d(1, 0, 4'h0, 32'h20, 32'h0);
      cycle();
      idle(4);

      // Random traffic; a request not granted is held unchanged.
      for (int i = 0; i < 400; i++) begin
         if (!(c_req && !last_gc)) begin
            c_req = ($urandom_range(0, 9) < 6);
            c_wr  = 1'($urandom_range(0, 1));
            c_wstrb = 4'($urandom_range(0, 15));
            c_addr  = 32'($urandom_range(0, 31)) << 2;
            c_wdata = $urandom;
         end
         if (!(d_req && !last_gd)) begin
            d_req = ($urandom_range(0, 9) < 5);
            d_wr  = 1'($urandom_range(0, 1));
            d_wstrb = 4'($urandom_range(0, 15));
            d_addr  = 32'($urandom_range(0, 31)) << 2;
            d_wdata = $urandom;
         end
         cycle();
      end
      idle(5);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
